// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial adder with a small IDLE/RUN/DONE controller. One addition
//   computes A + B + Cin (modulo 2^WIDTH) through a single 1-bit full adder.
//   The adder works LSB first, one bit per clock. The result and carry-out
//   are published on a one-cycle done pulse.
//
//   Ports
//     clk   in   rising-edge clock
//     rst   in   synchronous active-high reset
//     start in   begin one addition (accepted only in IDLE, never queued)
//     A, B  in   operands, WIDTH bits, captured on the accepted start edge
//     Cin   in   carry-in, captured on the accepted start edge
//     busy  out  high while the bits are being computed
//     done  out  one-cycle pulse when SUM/Cout carry a new result
//     SUM   out  registered sum, held until the next completed addition
//     Cout  out  registered carry-out of the top bit
// -----------------------------------------------------------------------------

// One-bit full adder used as the single arithmetic element of the serial path.
module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] SUM,
  output logic             Cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              carry;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic [WIDTH-1:0]  res;
  logic [WIDTH-1:0]  res_nxt;
  logic              fa_s;
  logic              fa_co;

  serial_adder_fa u_fa (
    .a  (a_reg[cnt]),
    .b  (b_reg[cnt]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // New bit enters at the MSB and older bits move down. After WIDTH shifts,
  // bit 0 of the sum has reached position 0.
  always_comb begin
    res_nxt = res;
    res_nxt[WIDTH-1] = fa_s;
    for (int i = 0; i < WIDTH - 1; i++) begin
      res_nxt[i] = res[i+1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      SUM   <= '0;
      Cout  <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= A;
            b_reg <= B;
            carry <= Cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          res   <= res_nxt;
          carry <= fa_co;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            // The top bit's carry goes only to Cout, so SUM wraps modulo 2^WIDTH.
            SUM   <= res_nxt;
            Cout  <= fa_co;
            busy  <= 1'b0;
            done  <= 1'b1;
            cnt   <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] SUM;
  logic         Cout;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .SUM   (SUM),
    .Cout  (Cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst) busy_cnt = 0;
    else if (busy) busy_cnt++;
    if (busy && done) chk("busy_and_done", 1, 0);
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("sum", 32'(SUM), 32'(e.sum));
        chk("cout", 32'(Cout), 32'(e.cout));
        chk("latency_cycle", 32'(cyc), 32'(e.cyc));
        chk("busy_cycles", 32'(busy_cnt), 32'(W));
      end
      busy_cnt = 0;
    end
  end

  // Called at a negedge; start is sampled at the next posedge (index cyc+1).
  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic [W-1:0] s,
                          input logic co, input bit push);
    exp_t e;
    A = a; B = b; Cin = ci; start = 1'b1;
    if (push) begin
      e.sum = s; e.cout = co; e.cyc = cyc + 1 + W;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 32'(q.size()), 0);
    @(negedge clk);
  endtask

  task automatic chk_outs(input string tag, input logic [W-1:0] s, input logic co);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_SUM"}, 32'(SUM), 32'(s));
    chk({tag, "_Cout"}, 32'(Cout), 32'(co));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_outs("reset", 8'h00, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    do_start(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1);
    drain();
    do_start(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1);
    drain();
    do_start(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1);
    drain();

    // Operand changes and a start pulse mid-RUN must not disturb the result.
    do_start(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1);
    A = 8'hFF; B = 8'hFF; Cin = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b1;
    chk("hold_SUM", 32'(SUM), 32'h0FF);
    chk("hold_Cout", 32'(Cout), 1);
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (12) @(negedge clk);

    // Abort in the 4th RUN cycle.
    do_start(8'h77, 8'h11, 1'b0, 8'h00, 1'b0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_outs("abort", 8'h00, 1'b0);
    repeat (12) @(negedge clk);

    // Start on the first edge after reset is released.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_start(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1);
    drain();

    // start held high: accepted every W+2 cycles.
    begin
      exp_t e;
      A = 8'h10; B = 8'h20; Cin = 1'b0; start = 1'b1;
      for (int i = 0; i < 3; i++) begin
        e.sum = 8'h30; e.cout = 1'b0; e.cyc = cyc + 1 + W + i * (W + 2);
        q.push_back(e);
      end
      repeat (3 * (W + 2)) @(negedge clk);
      start = 1'b0;
    end
    drain();
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter: WIDTH, default 8, operand width in bits (legal range 1..32).
REQ-002 The block SHALL have port: clk  input  1  rising-edge clock, the only clock.
REQ-003 The block SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port: start  input  1  request to begin one addition.
REQ-005 The block SHALL have port: A  input  WIDTH  operand A, sampled only when start is accepted.
REQ-006 The block SHALL have port: B  input  WIDTH  operand B, sampled only when start is accepted.
REQ-007 The block SHALL have port: Cin  input  1  carry-in, sampled only when start is accepted.
REQ-008 The block SHALL have port: busy  output  1  high while an addition is in progress.
REQ-009 The block SHALL have port: done  output  1  single-cycle pulse marking a valid new result.
REQ-010 The block SHALL have port: SUM  output  WIDTH  registered result, A+B+Cin modulo 2^WIDTH.
REQ-011 The block SHALL have port: Cout  output  1  registered carry-out of the addition.

Function
REQ-012 The block SHALL compute the sum bit-serially through exactly one 1-bit full-adder instance (sum = a^b^c, carry = ab|c(a^b)), processing LSB first, one bit per clock.
REQ-013 The block SHALL implement states IDLE, RUN and DONE, with the state, bit counter and carry held in registers.
REQ-014 In IDLE, start=1 at a rising edge SHALL load A, B into shift registers, load carry with Cin, clear the bit counter to 0 and move to RUN.
REQ-015 In RUN, each edge SHALL compute bit[counter], shift it into an internal result register, update carry, and increment the counter.
REQ-016 On the edge computing bit WIDTH-1, the block SHALL move to DONE and copy the internal result to SUM and the final carry to Cout.
REQ-017 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-018 If start is sampled at edge k, busy SHALL be 1 from edge k through edge k+WIDTH-1, and done SHALL be 1 only between edges k+WIDTH and k+WIDTH+1.
REQ-019 The latency from the start edge to done SHALL be WIDTH cycles; the minimum start-to-start spacing SHALL be WIDTH+2 cycles.
REQ-020 start SHALL be ignored in RUN and DONE; it SHALL NOT be queued.
REQ-021 A, B and Cin changes after the accepted start edge SHALL NOT affect the in-progress result.
REQ-022 SUM and Cout SHALL hold the previous result throughout RUN and IDLE until the next DONE update.
REQ-023 The carry out of bit WIDTH-1 SHALL appear only on Cout, never in SUM (wrap-around modulo 2^WIDTH).
REQ-024 busy and done SHALL never be high in the same cycle.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, busy=0, done=0, SUM=0, Cout=0, carry=0 and counter=0, overriding start.
REQ-026 Reset asserted during RUN or DONE SHALL abort the operation: no done pulse and no SUM/Cout update for it.
REQ-027 start high at the first edge after rst falls SHALL be accepted normally.

Verification (WIDTH=8)
REQ-028 Start with A=0x00, B=0x00, Cin=0 -> done exactly 8 edges after start; SUM=0x00, Cout=0; busy high for 8 cycles.
REQ-029 Start with A=0xFF, B=0x01, Cin=0 -> SUM=0x00, Cout=1 (wrap-around).
REQ-030 Start with A=0xFF, B=0xFF, Cin=1 -> SUM=0xFF, Cout=1.
REQ-031 Start with A=0x5A, B=0x3C, Cin=0, then change A/B and pulse start mid-RUN -> single done; SUM=0x96, Cout=0.
REQ-032 rst pulsed in the 4th RUN cycle -> busy=0, done=0, SUM=0x00, Cout=0 the next cycle, and no done pulse follows; a new start with A=0x01, B=0x02, Cin=0 then gives SUM=0x03.
REQ-033 start held high continuously with A=0x10, B=0x20, Cin=0 -> done pulses every 10 cycles, each with SUM=0x30, Cout=0.
